// File: rtl/sin_rom_pkg.sv
// sin_rom_pkg: shared constants and types for the sine ROM arbiter slice.
//   ROM_DEPTH   number of valid entries in the sine ROM
//   QUARTER     cos phase offset applied by requesters (quarter period)
//   ADDR_W      default ROM address width
//   DATA_W      default ROM data width
//   req_id_t    requester id (0 = sin port, 1 = cos port)
//   tag_t       in-flight read tag {valid, id}
package sin_rom_pkg;

    localparam int unsigned ROM_DEPTH = 1000;
    localparam int unsigned QUARTER   = 250;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned DATA_W    = 16;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/sin_rom_arbiter_tag_pipe.sv
// rom_tag_pipe: DEPTH-stage shift register of read tags that tracks which
// requester owns the ROM word currently travelling through the ROM pipeline.
// Ports:
//   clk      system clock
//   rst      synchronous active-high clear of every stage
//   tag_in   tag loaded into stage 0 every cycle
//   tag_out  tag in the last stage (aligned with rom_dout)
module rom_tag_pipe
    import sin_rom_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t [DEPTH-1:0] stages;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages[0] <= tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/sin_rom_arbiter.sv
// sin_rom_arbiter: round-robin sharing of one single-port sine ROM between two
// requesters (port 0 = sin generator, port 1 = cos generator).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req0/addr0/gnt0        requester 0 handshake (gnt is combinational)
//   rdata0/rvalid0         requester 0 return data (held) and one-cycle valid
//   req1/addr1/gnt1        requester 1 handshake
//   rdata1/rvalid1         requester 1 return data and valid
//   rom_ena/rom_addr       ROM read port (combinational from the grant)
//   rom_dout               ROM data, valid ROM_LAT cycles after the read
//   oor_err                sticky: an address >= ROM_DEPTH was accepted
module sin_rom_arbiter #(
    parameter int unsigned ADDR_W    = sin_rom_pkg::ADDR_W,
    parameter int unsigned DATA_W    = sin_rom_pkg::DATA_W,
    parameter int unsigned ROM_DEPTH = sin_rom_pkg::ROM_DEPTH,
    parameter int unsigned ROM_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid1,
    output logic              rom_ena,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic              oor_err
);

    import sin_rom_pkg::*;

    // 0: requester 0 wins a tie, 1: requester 1 wins a tie
    logic              ptr_q;
    logic [ADDR_W-1:0] sel_addr;
    logic              addr_oor;
    tag_t              tag_in;
    tag_t              tag_out;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && (!req1 || !ptr_q)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign rom_ena  = gnt0 | gnt1;
    assign sel_addr = gnt1 ? addr1 : addr0;

    // Compare in 32 bits so a ROM_DEPTH equal to 2**ADDR_W does not truncate.
    assign addr_oor = 32'(sel_addr) >= ROM_DEPTH;
    assign rom_addr = addr_oor ? sel_addr - ADDR_W'(ROM_DEPTH) : sel_addr;

    always_comb begin
        tag_in       = '0;
        tag_in.valid = rom_ena;
        tag_in.id    = gnt1;
    end

    rom_tag_pipe #(
        .DEPTH (ROM_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= 1'b0;
            oor_err <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            if (rom_ena) begin
                // Hand the tie to the requester that was not just served.
                ptr_q <= gnt0;
                if (addr_oor) begin
                    oor_err <= 1'b1;
                end
            end
            if (tag_out.valid) begin
                if (tag_out.id) begin
                    rdata1  <= rom_dout;
                    rvalid1 <= 1'b1;
                end else begin
                    rdata0  <= rom_dout;
                    rvalid0 <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sin_rom_arbiter.sv
// Bench for sin_rom_arbiter: two instances (ROM_LAT=1 and ROM_LAT=3) driven by
// the same requests, each with a ROM returning addr*7, checked every cycle
// against a queue-based model plus directed literal expectations.
module tb_sin_rom_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [9:0] addr0 = '0;
    logic [9:0] addr1 = '0;

    logic [1:0]  gnt0_v, gnt1_v, rvalid0_v, rvalid1_v, rom_ena_v, oor_v;
    logic [15:0] rdata0_v [2];
    logic [15:0] rdata1_v [2];
    logic [15:0] rom_dout_v [2];
    logic [9:0]  rom_addr_v [2];

    sin_rom_arbiter #(.ROM_LAT(1)) u_dut_lat1 (
        .clk (clk), .rst (rst),
        .req0 (req0), .addr0 (addr0), .gnt0 (gnt0_v[0]), .rdata0 (rdata0_v[0]),
        .rvalid0 (rvalid0_v[0]),
        .req1 (req1), .addr1 (addr1), .gnt1 (gnt1_v[0]), .rdata1 (rdata1_v[0]),
        .rvalid1 (rvalid1_v[0]),
        .rom_ena (rom_ena_v[0]), .rom_addr (rom_addr_v[0]), .rom_dout (rom_dout_v[0]),
        .oor_err (oor_v[0])
    );

    sin_rom_arbiter #(.ROM_LAT(3)) u_dut_lat3 (
        .clk (clk), .rst (rst),
        .req0 (req0), .addr0 (addr0), .gnt0 (gnt0_v[1]), .rdata0 (rdata0_v[1]),
        .rvalid0 (rvalid0_v[1]),
        .req1 (req1), .addr1 (addr1), .gnt1 (gnt1_v[1]), .rdata1 (rdata1_v[1]),
        .rvalid1 (rvalid1_v[1]),
        .rom_ena (rom_ena_v[1]), .rom_addr (rom_addr_v[1]), .rom_dout (rom_dout_v[1]),
        .oor_err (oor_v[1])
    );

    // ROM models: data = addr*7, registered through ROM_LAT stages.
    logic [15:0] rom1_q;
    logic [15:0] rom3_q [3];
    always @(posedge clk) begin
        rom1_q    <= rom_ena_v[0] ? 16'(rom_addr_v[0] * 7) : 16'hdead;
        rom3_q[0] <= rom_ena_v[1] ? 16'(rom_addr_v[1] * 7) : 16'hdead;
        rom3_q[1] <= rom3_q[0];
        rom3_q[2] <= rom3_q[1];
    end
    assign rom_dout_v[0] = rom1_q;
    assign rom_dout_v[1] = rom3_q[2];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Return pulse counters per instance and port.
    int rv0_cnt [2] = '{0, 0};
    int rv1_cnt [2] = '{0, 0};
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rvalid0_v[d] === 1'b1) rv0_cnt[d]++;
            if (rvalid1_v[d] === 1'b1) rv1_cnt[d]++;
        end
    end

    // Behavioural model: expected grants from the round-robin rule, returns
    // queued with their due cycle (grant cycle + latency + 1).
    typedef struct {
        int dut;
        int id;
        int data;
        int due;
    } ret_t;

    ret_t pend[$];
    int   cyc = 0;
    bit   chk_on = 1'b0;
    bit   mptr [2] = '{0, 0};
    bit   moor [2] = '{0, 0};
    int   mrd0 [2] = '{0, 0};
    int   mrd1 [2] = '{0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : model
        bit eg0, eg1;
        int ea, ma;
        bit ev0 [2];
        bit ev1 [2];
        ret_t r;
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                ev0[d] = 1'b0;
                ev1[d] = 1'b0;
            end
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].due == cyc) begin
                    if (pend[i].id == 0) begin
                        ev0[pend[i].dut]  = 1'b1;
                        mrd0[pend[i].dut] = pend[i].data;
                    end else begin
                        ev1[pend[i].dut]  = 1'b1;
                        mrd1[pend[i].dut] = pend[i].data;
                    end
                    pend.delete(i);
                end
            end
            for (int d = 0; d < 2; d++) begin
                eg0 = !rst && req0 && (!req1 || !mptr[d]);
                eg1 = !rst && req1 && !eg0;
                ea  = eg1 ? int'(addr1) : int'(addr0);
                ma  = (ea >= 1000) ? ea - 1000 : ea;
                check($sformatf("dut%0d gnt0 cyc%0d", d, cyc), gnt0_v[d], eg0);
                check($sformatf("dut%0d gnt1 cyc%0d", d, cyc), gnt1_v[d], eg1);
                check($sformatf("dut%0d rom_ena cyc%0d", d, cyc), rom_ena_v[d], eg0 | eg1);
                if (eg0 || eg1) begin
                    check($sformatf("dut%0d rom_addr cyc%0d", d, cyc), rom_addr_v[d], ma);
                end
                check($sformatf("dut%0d rvalid0 cyc%0d", d, cyc), rvalid0_v[d], ev0[d]);
                check($sformatf("dut%0d rvalid1 cyc%0d", d, cyc), rvalid1_v[d], ev1[d]);
                check($sformatf("dut%0d rdata0 cyc%0d", d, cyc), rdata0_v[d], mrd0[d]);
                check($sformatf("dut%0d rdata1 cyc%0d", d, cyc), rdata1_v[d], mrd1[d]);
                check($sformatf("dut%0d oor_err cyc%0d", d, cyc), oor_v[d], moor[d]);
                if (rst) begin
                    mptr[d] = 1'b0;
                    moor[d] = 1'b0;
                    mrd0[d] = 0;
                    mrd1[d] = 0;
                end else if (eg0 || eg1) begin
                    r.dut  = d;
                    r.id   = eg1 ? 1 : 0;
                    r.data = (ma * 7) & 16'hffff;
                    r.due  = cyc + ((d == 0) ? 1 : 3) + 1;
                    pend.push_back(r);
                    mptr[d] = eg0;
                    if (ea >= 1000) moor[d] = 1'b1;
                end
            end
            if (rst) pend.delete();
        end
    end

    int snap0 [2];
    int snap1 [2];

    initial begin
        rst = 1'b1;
        tick(1);
        chk_on = 1'b1;
        tick(1);
        rst = 1'b0;

        // Single read on port 0
        req0 = 1'b1; addr0 = 10'd10; #1;
        check("t1 gnt0", gnt0_v[0], 1);
        check("t1 gnt1", gnt1_v[0], 0);
        check("t1 rom_addr", rom_addr_v[0], 10);
        tick(1); req0 = 1'b0;
        tick(1);
        check("t1 lat1 rvalid0", rvalid0_v[0], 1);
        check("t1 lat1 rdata0", rdata0_v[0], 70);
        check("t1 lat1 rvalid1", rvalid1_v[0], 0);
        tick(2);
        check("t1 lat3 rvalid0", rvalid0_v[1], 1);
        check("t1 lat3 rdata0", rdata0_v[1], 70);

        // Solo grant to port 1 so the tie pointer returns to port 0
        req1 = 1'b1; addr1 = 10'd3; #1;
        check("t2 solo gnt1", gnt1_v[0], 1);
        tick(1); req1 = 1'b0;
        tick(4);

        // Contention: both held 4 cycles, grants alternate starting at 0
        snap0 = rv0_cnt; snap1 = rv1_cnt;
        req0 = 1'b1; req1 = 1'b1; addr0 = 10'd100; addr1 = 10'd350;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t2 gnt0 step%0d", i), gnt0_v[0], (i % 2) == 0);
            check($sformatf("t2 gnt1 step%0d", i), gnt1_v[0], (i % 2) == 1);
            tick(1);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(5);
        check("t2 rdata0", rdata0_v[0], 700);
        check("t2 rdata1", rdata1_v[0], 2450);
        check("t2 lat3 rdata1", rdata1_v[1], 2450);
        check("t2 returns0", rv0_cnt[0] - snap0[0], 2);
        check("t2 returns1", rv1_cnt[0] - snap1[0], 2);
        check("t2 lat3 returns0", rv0_cnt[1] - snap0[1], 2);

        // Pointer fairness
        req1 = 1'b1; addr1 = 10'd1; #1;
        check("t3 solo1", gnt1_v[0], 1);
        tick(1);
        req0 = 1'b1; addr0 = 10'd2; addr1 = 10'd2; #1;
        check("t3 tie after 1 gnt0", gnt0_v[0], 1);
        check("t3 tie after 1 gnt1", gnt1_v[0], 0);
        tick(1); req0 = 1'b0; req1 = 1'b0;
        req0 = 1'b1; addr0 = 10'd4; #1;
        check("t3 solo0", gnt0_v[0], 1);
        tick(1);
        req1 = 1'b1; addr1 = 10'd5; #1;
        check("t3 tie after 0 gnt1", gnt1_v[0], 1);
        check("t3 tie after 0 gnt0", gnt0_v[0], 0);
        tick(1); req0 = 1'b0; req1 = 1'b0;
        tick(6);

        // Wrap and sticky error
        req1 = 1'b1; addr1 = 10'd1005; #1;
        check("t4 rom_addr lat1", rom_addr_v[0], 5);
        check("t4 rom_addr lat3", rom_addr_v[1], 5);
        check("t4 oor before", oor_v[0], 0);
        tick(1); req1 = 1'b0;
        check("t4 oor set", oor_v[0], 1);
        tick(1);
        check("t4 rvalid1", rvalid1_v[0], 1);
        check("t4 rdata1", rdata1_v[0], 35);
        tick(10);
        check("t4 oor sticky lat1", oor_v[0], 1);
        check("t4 oor sticky lat3", oor_v[1], 1);
        check("t4 lat3 rdata1", rdata1_v[1], 35);
        rst = 1'b1; #1;
        check("t4 gnt in reset", gnt1_v[0], 0);
        tick(1); rst = 1'b0;
        check("t4 oor cleared", oor_v[0], 0);

        // Reset with a read in flight
        req0 = 1'b1; addr0 = 10'd20; #1;
        check("t5 gnt0", gnt0_v[0], 1);
        tick(1); req0 = 1'b0; rst = 1'b1;
        snap0 = rv0_cnt;
        tick(1); rst = 1'b0;
        tick(5);
        check("t5 no rvalid lat1", rv0_cnt[0] - snap0[0], 0);
        check("t5 no rvalid lat3", rv0_cnt[1] - snap0[1], 0);
        check("t5 rdata0 lat1", rdata0_v[0], 0);
        check("t5 rdata0 lat3", rdata0_v[1], 0);
        req0 = 1'b1; req1 = 1'b1; addr0 = 10'd6; addr1 = 10'd7; #1;
        check("t5 first tie gnt0", gnt0_v[0], 1);
        tick(1); req0 = 1'b0;
        tick(1); req1 = 1'b0;
        tick(6);

        // Back-to-back reads on port 0, checked on the ROM_LAT=3 instance
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    req0 = 1'b1; addr0 = 10'(i + 1);
                    tick(1);
                end
                req0 = 1'b0;
            end
            begin
                tick(3);
                check("t6 lat3 not yet", rvalid0_v[1], 0);
                tick(1);
                for (int i = 0; i < 5; i++) begin
                    check($sformatf("t6 lat3 rvalid0 %0d", i), rvalid0_v[1], 1);
                    check($sformatf("t6 lat3 rdata0 %0d", i), rdata0_v[1], 7 * (i + 1));
                    tick(1);
                end
                check("t6 lat3 done", rvalid0_v[1], 0);
            end
        join
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sin_rom_arbiter.md
Name: sin_rom_arbiter

Overview:
- Shares the single sine lookup ROM (1000 x 16-bit, single read port, registered output) between two waveform requesters, e.g. the sine channel and the cosine channel.
- Port 0 and port 1 are assumed to be the sin and cos generators. The arbiter does not decide which generator uses which port.
- Arbitration is round-robin with a req/gnt handshake, which allows at most one ROM read per cycle.
- Read data comes back to the requester that issued the read, with a one-cycle valid pulse.

Parameters:
- ADDR_W, 10: ROM address width.
- DATA_W, 16: ROM data width.
- ROM_DEPTH, 1000: number of valid ROM entries.
- ROM_LAT, 1: cycles from rom_ena/rom_addr being sampled to rom_dout being valid. Legal range is 1..4.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 read request. Held high until granted.
- addr0  in  ADDR_W  requester 0 address. Must be stable while req0=1 and gnt0=0.
- gnt0  out  1  requester 0 granted this cycle. Combinational.
- rdata0  out  DATA_W  requester 0 read data. Registered and held.
- rvalid0  out  1  one-cycle pulse: rdata0 was updated this cycle.
- req1, addr1, gnt1, rdata1, rvalid1: same meanings for requester 1.
- rom_ena  out  1  ROM enable. Combinational, equals gnt0|gnt1.
- rom_addr  out  ADDR_W  ROM address. Combinational, from the granted requester.
- rom_dout  in  DATA_W  ROM read data.
- oor_err  out  1  sticky flag: an out-of-range address was accepted.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Priority pointer goes to 0, so requester 0 wins the first tie.
  - Tag pipeline is cleared.
  - rdata0 = rdata1 = 0, rvalid0 = rvalid1 = 0, oor_err = 0.
  - While rst=1, gnt0 = gnt1 = 0 and rom_ena = 0.
- Grant rule (combinational from req and pointer):
  - Only one requester asserting: it is granted.
  - Both asserting: the requester selected by the pointer is granted.
  - Neither asserting: no grant, rom_ena = 0.
- Pointer update (at a clk edge, after a grant):
  - After granting requester k, pointer = 1-k.
  - The pointer is unchanged in cycles with no grant.
  - Consequence: with both requests held continuously, grants alternate 0,1,0,1. Neither requester waits more than 1 cycle.
- Handshake:
  - A request is consumed in a cycle where req=1 and gnt=1.
  - The requester may present a new address and keep req high in the next cycle (back-to-back reads).
  - Dropping req before it is granted is allowed. Nothing is read and there is no penalty.
- Address handling:
  - Addresses in 0..ROM_DEPTH-1 pass through unchanged.
  - Addresses >= ROM_DEPTH wrap to addr - ROM_DEPTH; 1000..1023 map to 0..23.
  - Any accepted wrapped address sets oor_err, which stays set until reset.
- Tag pipeline:
  - ROM_LAT-deep shift register of {valid, id}.
  - Stage 0 loads {rom_ena, granted id} every cycle.
- Return path:
  - When the last stage holds valid=1, the next clk edge loads rom_dout into rdata[id] and makes rvalid[id]=1 for one cycle.
  - Total latency from grant cycle to rvalid is ROM_LAT+1 cycles.
  - rdata of the other requester holds its value.
- Ordering: returns come back in grant order. Each requester sees in-order data.
- Throughput: one read per cycle, fully pipelined, no bubbles.
- Reset mid-operation: in-flight tags are discarded. No rvalid is produced for reads granted before reset.
- Simultaneous events: a new grant and a return in the same cycle are independent, including to the same requester.

Decomposition:
- Package sin_rom_pkg holds:
  - ROM_DEPTH = 1000.
  - QUARTER = 250, the cos phase offset used by requesters.
  - ADDR_W and DATA_W defaults.
  - A requester-id typedef (1 bit).
  - A tag struct {valid, id}.
- One sub-module, rom_tag_pipe: a parameterised ROM_LAT-stage shift register of tag structs with a synchronous clear.

Test Plan:
- Bench ROM model: returns rom_dout = addr*7 (16-bit), ROM_LAT=1.
- Single requester: req0=1, addr0=10 for one cycle -> gnt0=1 that cycle; rom_addr=10; rvalid0 pulses 2 cycles later with rdata0=70; rvalid1 stays 0.
- Contention: req0 and req1 held for 4 cycles with addr0=100, addr1=350 -> grant order is 0,1,0,1; rdata0=700 and rdata1=2450 alternate with one rvalid per cycle; each requester receives 2 returns.
- Pointer fairness: after granting 1 alone, assert both in the same cycle -> requester 0 is granted first. After granting 0 alone, both asserted -> requester 1 is granted first.
- Wrap/error: addr1=1005 -> rom_addr=5, rdata1=35, oor_err=1 and still 1 after 10 idle cycles; after rst, oor_err=0.
- Reset mid-flight: grant addr0=20, then assert rst on the next cycle -> rvalid0 never pulses; rdata0=0; first grant after reset goes to requester 0.
- Latency sweep with ROM_LAT=3: back-to-back reads on port 0 at addresses 1..5 -> rvalid0 starts 4 cycles after the first grant; data 7,14,21,28,35 arrive on consecutive cycles.
